mxrv_csr_access: RTL

- Initiator side of the CSR register-file read/write port; executes Zicsr instructions (CSRRW/RS/RC and immediate forms) as a sequenced read-modify-write.
- Sits in the execute stage, between the decoder/regfile operand path and mxrv_csr_reg.
- Returns the old CSR value to rd and stalls the pipeline while the access is in flight. The CSR file returns read data registered, one cycle after the address is presented.

---
 rtl/mxrv_csr_access_pkg.sv | 40 ++++
 rtl/mxrv_csr_access_if.sv | 13 +
 rtl/mxrv_csr_alu.sv | 22 ++
 rtl/mxrv_csr_access.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mxrv_csr_access_pkg.sv
// Shared constants for the Zicsr access unit: SYSTEM opcode, funct3 codes,
// FSM state encoding and CSR address map shared with mxrv_csr_reg.
package mxrv_csr_access_pkg;

    localparam logic RstEnable = 1'b1;

    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [2:0] F3Csrrw  = 3'b001;
    localparam logic [2:0] F3Csrrs  = 3'b010;
    localparam logic [2:0] F3Csrrc  = 3'b011;
    localparam logic [2:0] F3Csrrwi = 3'b101;
    localparam logic [2:0] F3Csrrsi = 3'b110;
    localparam logic [2:0] F3Csrrci = 3'b111;

    localparam logic [1:0] AluWrite = 2'b01;
    localparam logic [1:0] AluSet   = 2'b10;
    localparam logic [1:0] AluClear = 2'b11;

    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrCycle    = 12'hC00;
    localparam logic [11:0] CsrMhartid  = 12'hF14;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StRead  = 3'd1,
        StCapt  = 3'd2,
        StWrite = 3'd3,
        StErr   = 3'd4
    } csr_state_e;

    // Top two address bits 2'b11 mark a read-only CSR.
    function automatic logic csr_is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/mxrv_csr_access_if.sv
// Read/write port between the CSR access unit (master) and the CSR file (slave).
interface mxrv_csr_access_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
);
    logic [CSR_AW-1:0] csr_addr;
    logic              csr_we;
    logic [XLEN-1:0]   csr_wdata;
    logic [XLEN-1:0]   csr_rdata;

    modport master (output csr_addr, output csr_we, output csr_wdata, input csr_rdata);
    modport slave  (input csr_addr, input csr_we, input csr_wdata, output csr_rdata);
endinterface

// File: rtl/mxrv_csr_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC.
module mxrv_csr_alu
    import mxrv_csr_access_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [1:0]      f3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] operand_i,
    output logic [XLEN-1:0] new_o
);

    always_comb begin
        new_o = operand_i;
        case (f3_i)
            AluSet:   new_o = old_i | operand_i;
            AluClear: new_o = old_i & ~operand_i;
            default:  new_o = operand_i;
        endcase
    end

endmodule

// File: rtl/mxrv_csr_access.sv
// Zicsr execute-stage unit: sequences READ -> CAPT -> WRITE against the CSR file
// and returns the old CSR value for rd writeback.
module mxrv_csr_access
    import mxrv_csr_access_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CSR_AW = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         inst_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic                flush_i,
    mxrv_csr_access_if.master   csr_bus,
    output logic                done_o,
    output logic                illegal_o,
    output logic                rd_we_o,
    output logic [4:0]          rd_addr_o,
    output logic [XLEN-1:0]     rd_wdata_o
);

    csr_state_e        state_q;
    logic [4:0]        rd_q;
    logic [1:0]        alu_op_q;
    logic [XLEN-1:0]   operand_q;
    logic              wr_en_q;
    logic [CSR_AW-1:0] csr_addr_q;
    logic              csr_we_q;
    logic [XLEN-1:0]   csr_wdata_q;
    logic              done_q;
    logic              illegal_q;
    logic              rd_we_q;
    logic [4:0]        rd_addr_q;
    logic [XLEN-1:0]   rd_wdata_q;

    logic [2:0]      dec_f3;
    logic            dec_wr_en;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_operand;
    logic [XLEN-1:0] alu_new;

    // Set/clear with a zero source is a pure read, so it is legal on read-only CSRs.
    always_comb begin
        dec_f3      = inst_i[14:12];
        dec_wr_en   = (dec_f3[1:0] == AluWrite) || (inst_i[19:15] != 5'd0);
        dec_illegal = (inst_i[6:0] != OpcSystem) || (dec_f3[1:0] == 2'b00) ||
                      (dec_wr_en && csr_is_ro(inst_i[31:20]));
        dec_operand = dec_f3[2] ? XLEN'(inst_i[19:15]) : rs1_data_i;
    end

    mxrv_csr_alu #(
        .XLEN (XLEN)
    ) u_alu (
        .f3_i      (alu_op_q),
        .old_i     (csr_bus.csr_rdata),
        .operand_i (operand_q),
        .new_o     (alu_new)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q     <= StIdle;
            rd_q        <= '0;
            alu_op_q    <= '0;
            operand_q   <= '0;
            wr_en_q     <= 1'b0;
            csr_addr_q  <= '0;
            csr_we_q    <= 1'b0;
            csr_wdata_q <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            rd_we_q     <= 1'b0;
            rd_addr_q   <= '0;
            rd_wdata_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            rd_we_q   <= 1'b0;
            csr_we_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && !flush_i) begin
                        rd_q      <= inst_i[11:7];
                        alu_op_q  <= dec_f3[1:0];
                        operand_q <= dec_operand;
                        wr_en_q   <= dec_wr_en;
                        if (dec_illegal) begin
                            state_q   <= StErr;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end else begin
                            state_q    <= StRead;
                            csr_addr_q <= CSR_AW'(inst_i[31:20]);
                        end
                    end
                end
                StRead: begin
                    if (flush_i) begin
                        state_q    <= StIdle;
                        csr_addr_q <= '0;
                    end else begin
                        state_q <= StCapt;
                    end
                end
                StCapt: begin
                    if (flush_i) begin
                        state_q    <= StIdle;
                        csr_addr_q <= '0;
                    end else begin
                        // Read data arrives this cycle; it is both the rd value and the ALU input.
                        state_q     <= StWrite;
                        csr_we_q    <= wr_en_q;
                        csr_wdata_q <= alu_new;
                        done_q      <= 1'b1;
                        rd_we_q     <= (rd_q != 5'd0);
                        rd_addr_q   <= rd_q;
                        rd_wdata_q  <= csr_bus.csr_rdata;
                    end
                end
                StWrite: begin
                    state_q     <= StIdle;
                    csr_addr_q  <= '0;
                    csr_wdata_q <= '0;
                    rd_addr_q   <= '0;
                    rd_wdata_q  <= '0;
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o       = (state_q == StIdle);
    assign csr_bus.csr_addr  = csr_addr_q;
    assign csr_bus.csr_we    = csr_we_q;
    assign csr_bus.csr_wdata = csr_wdata_q;
    assign done_o            = done_q;
    assign illegal_o         = illegal_q;
    assign rd_we_o           = rd_we_q;
    assign rd_addr_o         = rd_addr_q;
    assign rd_wdata_o        = rd_wdata_q;

endmodule
